// File: rtl/block_normaliser.sv
// Per-frame scaling controller: tracks the peak one's-complement magnitude of a frame of
// accumulator samples and searches for the smallest right-shift that fits OUT_W signed bits.
// Optional macro BLOCK_NORMALISER_DECAY_EN: immediate attack, one-step-per-frame release.
module block_normaliser #(
    parameter int SHIFT_W   = 5,
    parameter int MAX_SHIFT = 24,
    parameter int IN_W      = 40,
    parameter int OUT_W     = 16
) (
    input  logic                   ck,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic signed [IN_W-1:0] in,
    output logic [SHIFT_W-1:0]     shift,
    output logic                   shift_valid,
    output logic                   busy
);

    typedef enum logic [1:0] {ACCUM, SEARCH, DONE} state_t;

    state_t               r_state;
    logic [IN_W-1:0]      r_mag_acc;
    logic [IN_W-1:0]      r_mag_hold;
    logic [SHIFT_W-1:0]   r_s;
    logic [SHIFT_W-1:0]   r_result;
    logic [SHIFT_W-1:0]   r_shift;
    logic                 r_shift_valid;

    logic [IN_W-1:0]      w_mag;
    logic [IN_W-1:0]      w_hi;
    logic                 w_xfer;
    logic                 w_found;

    function automatic logic [IN_W-1:0] ones_mag(input logic signed [IN_W-1:0] x);
        return x ^ {IN_W{x[IN_W-1]}};
    endfunction

`ifdef BLOCK_NORMALISER_DECAY_EN
    function automatic logic [SHIFT_W-1:0] decay_step(input logic [SHIFT_W-1:0] res,
                                                      input logic [SHIFT_W-1:0] cur);
        if (res > cur)
            return res;
        else if (res < cur)
            return cur - 1'b1;
        else
            return cur;
    endfunction
`endif

    assign w_mag    = ones_mag(in);
    assign in_ready = (r_state == ACCUM);
    assign busy     = (r_state == SEARCH);
    assign w_xfer   = in_valid & in_ready;

    // Bits [IN_W-1 : OUT_W-1+s] of the held magnitude, right-aligned; zero means shift s fits.
    assign w_hi    = (r_mag_hold >> (OUT_W - 1)) >> r_s;
    assign w_found = (w_hi == '0) || (r_s == SHIFT_W'(MAX_SHIFT));

    assign shift       = r_shift;
    assign shift_valid = r_shift_valid;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ACCUM;
            r_mag_acc     <= '0;
            r_s           <= '0;
            r_shift       <= SHIFT_W'(MAX_SHIFT);
            r_shift_valid <= 1'b0;
        end else begin
            r_shift_valid <= 1'b0;
            case (r_state)
                ACCUM: begin
                    if (w_xfer) begin
                        if (in_last) begin
                            r_mag_acc <= '0;
                            r_s       <= '0;
                            r_state   <= SEARCH;
                        end else begin
                            r_mag_acc <= r_mag_acc | w_mag;
                        end
                    end
                end
                SEARCH: begin
                    if (w_found)
                        r_state <= DONE;
                    else
                        r_s <= r_s + 1'b1;
                end
                DONE: begin
`ifdef BLOCK_NORMALISER_DECAY_EN
                    r_shift <= decay_step(r_result, r_shift);
`else
                    r_shift <= r_result;
`endif
                    r_shift_valid <= 1'b1;
                    r_state       <= ACCUM;
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    // Frame peak and search result are pure data; control state qualifies them.
    always_ff @(posedge ck) begin
        if (r_state == ACCUM && w_xfer && in_last)
            r_mag_hold <= r_mag_acc | w_mag;
        if (r_state == SEARCH && w_found)
            r_result <= r_s;
    end

endmodule

// File: tb/tb_block_normaliser.sv
// Directed bench for block_normaliser: frame-level reference model plus per-cycle compare.
module tb_block_normaliser;

    logic                ck;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic signed [39:0]  in_s;
    logic [4:0]          shift;
    logic                shift_valid;
    logic                busy;

    int checks = 0;
    int errors = 0;

`ifdef BLOCK_NORMALISER_DECAY_EN
    localparam int F1 = 23, F2 = 22, Z1 = 23, Z2 = 22, N1 = 21, P32768 = 20, P32769 = 19, AR = 23;
`else
    localparam int F1 = 0, F2 = 1, Z1 = 0, Z2 = 0, N1 = 0, P32768 = 0, P32769 = 1, AR = 0;
`endif

    block_normaliser dut (
        .ck          (ck),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .in          (in_s),
        .shift       (shift),
        .shift_valid (shift_valid),
        .busy        (busy)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: smallest k such that every sample arithmetically shifted right by k fits 16 bits.
    function automatic int calc_shift(input logic signed [39:0] q[$]);
        logic signed [39:0] y;
        bit fits;
        for (int k = 0; k <= 24; k++) begin
            fits = 1'b1;
            foreach (q[i]) begin
                y = q[i] >>> k;
                if (y > 40'sd32767 || y < -40'sd32768) fits = 1'b0;
            end
            if (fits) return k;
        end
        return 24;
    endfunction

    function automatic int apply_shift(input int res, input int cur);
`ifdef BLOCK_NORMALISER_DECAY_EN
        if (res > cur) return res;
        if (res < cur) return cur - 1;
        return cur;
`else
        return res;
`endif
    endfunction

    logic signed [39:0] m_frame[$];
    int m_phase;
    int m_res;
    int exp_shift;
    bit exp_sv, exp_rdy, exp_busy;

    // Frame-level model: a frame closes at its last sample; result+1 search cycles, one
    // done cycle, then the new shift appears with a one-cycle valid pulse.
    always @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            m_frame.delete();
            m_phase   = -1;
            m_res     = 0;
            exp_shift = 24;
            exp_sv    = 1'b0;
        end else begin
            exp_sv = 1'b0;
            if (m_phase < 0) begin
                if (in_valid) begin
                    m_frame.push_back(in_s);
                    if (in_last) begin
                        m_res = calc_shift(m_frame);
                        m_frame.delete();
                        m_phase = 0;
                    end
                end
            end else begin
                m_phase++;
                if (m_phase == m_res + 2) begin
                    exp_shift = apply_shift(m_res, exp_shift);
                    exp_sv    = 1'b1;
                    m_phase   = -1;
                end
            end
        end
        exp_rdy  = (m_phase < 0);
        exp_busy = (m_phase >= 0) && (m_phase <= m_res);
    end

    always @(negedge ck) begin
        chk("in_ready", in_ready, exp_rdy);
        chk("busy", busy, exp_busy);
        chk("shift_valid", shift_valid, exp_sv);
        chk("shift", shift, exp_shift);
    end

    task automatic send(input logic signed [39:0] x, input logic last);
        int  g;
        logic ok;
        in_valid = 1'b1;
        in_s     = x;
        in_last  = last;
        g        = 0;
        do begin
            ok = in_ready;
            @(posedge ck);
            #1;
            g++;
        end while (!ok && g < 200);
        chk("accept", ok, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called just after the last-sample edge; measures edges to the shift_valid pulse.
    task automatic wait_pulse(output int lat, output int rdy_low, output int busy_n);
        bit seen;
        lat     = 0;
        rdy_low = !in_ready;
        busy_n  = busy;
        seen    = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge ck);
            #1;
            lat++;
            if (shift_valid) seen = 1'b1;
            else begin
                rdy_low += !in_ready;
                busy_n  += busy;
            end
        end
        if (!seen) chk("pulse_timeout", 0, 1);
    endtask

    task automatic frame_check(input string name, input int lit);
        chk(name, shift, lit);
        chk({name, "_model"}, exp_shift, lit);
    endtask

    initial begin
        int lat, rl, bn, sv_seen;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_s = '0;
        repeat (3) @(posedge ck);
        #1;
        chk("rst_shift", shift, 24);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sv", shift_valid, 0);
        rst_n = 1'b1;
        @(posedge ck); #1;

        send(100, 0); send(32767, 0); send(-5, 0); send(0, 1);
        wait_pulse(lat, rl, bn);
        chk("f1_lat", lat, 2);
        chk("f1_rdy_low", rl, 2);
        frame_check("f1_shift", F1);

        send(40'sh00_0000_8000, 1);
        wait_pulse(lat, rl, bn);
        chk("f2_lat", lat, 3);
        frame_check("f2_shift", F2);

        // Stray strobes during the search must not be taken as a new frame.
        send(40'sh7F_FFFF_FFFF, 1);
        in_valid = 1'b1; in_s = 40'sh00_0001_0000; in_last = 1'b1;
        wait_pulse(lat, rl, bn);
        in_valid = 1'b0; in_last = 1'b0;
        chk("f3_lat", lat, 26);
        chk("f3_busy", bn, 25);
        frame_check("f3_shift", 24);

        send(0, 1);
        wait_pulse(lat, rl, bn);
        frame_check("zero1_shift", Z1);
        send(0, 0); send(0, 1);
        wait_pulse(lat, rl, bn);
        frame_check("zero2_shift", Z2);
        send(-1, 0); send(-1, 1);
        wait_pulse(lat, rl, bn);
        frame_check("neg1_shift", N1);

        send(-40'sd32768, 1);
        wait_pulse(lat, rl, bn);
        chk("m32768_lat", lat, 2);
        frame_check("m32768_shift", P32768);
        send(-40'sd32769, 1);
        wait_pulse(lat, rl, bn);
        chk("m32769_lat", lat, 3);
        frame_check("m32769_shift", P32769);

        // Abort a shift-10 search with reset.
        send(40'sh00_0100_0000, 1);
        repeat (5) @(posedge ck);
        #1;
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_shift", shift, 24);
        chk("abort_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        @(posedge ck); #1;
        rst_n = 1'b1;
        sv_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge ck); #1;
            sv_seen += shift_valid;
        end
        chk("abort_no_pulse", sv_seen, 0);
        chk("abort_hold_shift", shift, 24);
        send(32767, 1);
        wait_pulse(lat, rl, bn);
        chk("after_rst_lat", lat, 2);
        frame_check("after_rst_shift", AR);

        repeat (3) @(posedge ck);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/block_normaliser.md
Name: block_normaliser

Overview:
- Per-frame scaling controller for the 40-bit accumulator to 16-bit shifter path.
- Observes a frame of 40-bit accumulator samples and finds the peak magnitude.
- Computes the smallest right-shift (0..24) that makes every sample of that frame fit a signed 16-bit window.
- Presents the result on a registered shift port that drives the shifter's shift input.

Parameters:
- SHIFT_W, 5, width of shift output.
- MAX_SHIFT, 24, largest shift produced; also the reset/safe value.
- IN_W, 40, accumulator sample width.
- OUT_W, 16, target signed output width.

Ports:
- ck  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample strobe.
- in_ready  output  1  block can accept a sample.
- in_last  input  1  marks final sample of a frame; qualified by in_valid & in_ready.
- in  input  IN_W  signed two's-complement accumulator sample.
- shift  output  SHIFT_W  current shift value for the shifter.
- shift_valid  output  1  one-cycle pulse when shift updates.
- busy  output  1  search in progress.

Behaviour:
- Reset (async, rst_n=0):
  - state=ACCUM, magnitude register mag_acc=0, search counter s=0.
  - shift=MAX_SHIFT, shift_valid=0, busy=0, in_ready=1.
- Sample transfer: occurs when in_valid & in_ready on a rising edge.
- Magnitude: m = in ^ {IN_W{in[IN_W-1]}} (one's-complement magnitude; bit IN_W-1 of m is always 0).
- ACCUM state:
  - Each transfer: mag_acc <= mag_acc | m.
  - Transfer with in_last=1: that sample's m is included; mag_hold <= mag_acc | m; mag_acc <= 0; s <= 0; go to SEARCH.
- SEARCH state:
  - in_ready=0 and busy=1; in_valid is ignored.
  - Each cycle: if mag_hold[IN_W-1 : OUT_W-1+s] == 0, then result=s and go to DONE.
  - Otherwise s <= s+1.
  - Always terminates by s=MAX_SHIFT, because bit IN_W-1 of every m is 0.
- DONE state (one cycle):
  - shift <= result (subject to the optional feature); shift_valid=1 for exactly this cycle.
  - in_ready=0; go to ACCUM.
- Latency: from the last-sample edge to the shift_valid pulse is result+2 cycles. in_ready returns high the cycle after DONE.
- shift is held between updates. The shifter sees the new value from the cycle after shift_valid.
- All-zero frame or all -1 frame: mag=0, so result=0.
- Single-sample frame (in_valid & in_last together in ACCUM): handled normally.
- Reset mid-SEARCH or mid-DONE: abort immediately to reset values; no shift_valid pulse; the partial frame is lost.
- Widths: the s comparison uses a variable lower bound. Implementation may use a mask or a per-step shifted copy of mag_hold, but must match the slice semantics above exactly.

Optional Feature:
- Macro: BLOCK_NORMALISER_DECAY_EN.
- Defined:
  - Attack immediate: if result > shift, shift <= result.
  - Release limited: if result < shift, shift <= shift-1.
  - Equal: unchanged.
  - shift_valid still pulses every frame.
- Undefined: shift <= result every frame.

Test Plan:
- Reset then frame {100, 32767, -5, 0} with in_last on 4th -> shift=0, shift_valid 2 cycles after last, in_ready low 2 cycles.
- Single-sample frame in=40'h00_0000_8000 -> shift=1, shift_valid 3 cycles after transfer.
- Frame containing 40'h7F_FFFF_FFFF -> shift=24; busy high 25 cycles; in_valid held high during search is not accepted (in_ready=0), frame contents unchanged.
- Frame {40'hFF_FFFF_8000 (-32768)} -> shift=0; frame {40'hFF_FFFF_7FFF (-32769)} -> shift=1.
- Frame giving 24 then frame of zeros -> shift=0 without macro; shift=23 with BLOCK_NORMALISER_DECAY_EN, 22 after a further zero frame.
- Assert rst_n=0 during SEARCH of a shift-10 frame -> shift=24, shift_valid never pulses, in_ready=1 after release; next frame {32767} -> shift=0.
